noise_lfsr_generator: RTL and testbench

Parametrised successor to the table-based noise source: pseudo-random noise from a 15-bit LFSR clocked by an exact fractional-rate phase accumulator. Supports long (32767-step) and short/"metallic" (93-step) modes, a run enable, and a per-sample strobe. Sits in the synth voice path alongside the sawtooth and other oscillators, feeding the mixer.

---
 rtl/noise_lfsr_generator.sv | 88 ++++++++
 tb/tb_noise_lfsr_generator.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/noise_lfsr_generator.sv
// 15-bit Fibonacci LFSR noise source advanced by an exact fractional-rate phase accumulator.
// Optional macro NOISE_SEED_LOAD_EN adds the seed/seed_load runtime reseed ports.
module noise_lfsr_generator #(
  parameter int          BASE_SPEED = 50000000,
  parameter int          WIDTH      = 8,
  parameter logic [14:0] SEED       = 15'h0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [19:0]      freq,
  input  logic             mode,
`ifdef NOISE_SEED_LOAD_EN
  input  logic [14:0]      seed,
  input  logic             seed_load,
`endif
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  localparam int          AW        = $clog2(BASE_SPEED) + 1;
  localparam int          SW        = ((AW > 20) ? AW : 20) + 1;
  localparam logic [SW-1:0] BASE_W  = SW'(BASE_SPEED);
  localparam logic [14:0] SEED_INIT = (SEED == 15'h0000) ? 15'h0001 : SEED;

  function automatic logic [14:0] fix_seed(input logic [14:0] s);
    return (s == 15'h0000) ? 15'h0001 : s;
  endfunction

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic [14:0]   lfsr;
  logic [SW-1:0] sum;
  logic          tick;
  logic          fast;
  logic          fb;
  logic          load;
  logic [14:0]   load_val;

`ifdef NOISE_SEED_LOAD_EN
  assign load     = seed_load;
  assign load_val = fix_seed(seed);
`else
  assign load     = 1'b0;
  assign load_val = SEED_INIT;
`endif

  // Rate stage: sum is wide enough that acc + freq never wraps
  always_comb begin
    sum      = SW'(acc) + SW'(freq);
    fast     = (SW'(freq) >= BASE_W);
    tick     = (sum >= BASE_W);
    acc_next = AW'(sum);
    if (fast)
      acc_next = '0;
    else if (tick)
      acc_next = AW'(sum - BASE_W);
    fb = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]);
  end

  // State stage: load beats lockup recovery, which beats normal run/hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc   <= '0;
      lfsr  <= SEED_INIT;
      valid <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      lfsr  <= load_val;
      valid <= 1'b0;
    end else if (lfsr == 15'h0000) begin
      acc   <= en ? acc_next : '0;
      lfsr  <= 15'h0001;
      valid <= 1'b0;
    end else if (!en) begin
      acc   <= '0;
      valid <= 1'b0;
    end else begin
      acc   <= acc_next;
      valid <= tick;
      if (tick)
        lfsr <= {fb, lfsr[14:1]};
    end
  end

  assign out = lfsr[14 -: WIDTH];

endmodule

// File: tb/tb_noise_lfsr_generator.sv
// Directed bench for noise_lfsr_generator at BASE_SPEED=100, WIDTH=8.
module tb_noise_lfsr_generator;

  logic        clk;
  logic        rst;
  logic        en;
  logic [19:0] freq;
  logic        mode;
  logic [14:0] seed;
  logic        seed_load;
  logic [7:0]  out;
  logic        valid;

  int checks = 0;
  int errors = 0;

  noise_lfsr_generator #(
    .BASE_SPEED(100),
    .WIDTH(8),
    .SEED(15'h0001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .freq(freq),
    .mode(mode),
`ifdef NOISE_SEED_LOAD_EN
    .seed(seed),
    .seed_load(seed_load),
`endif
    .out(out),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0]  exp_out  [3];
  logic [14:0] exp_lfsr [3];

  initial begin
    int n;
    int nv;
    int gap;
    int bad_gap;
    int nchg;
    logic [7:0] held;

    exp_out[0]  = 8'h80;    exp_out[1]  = 8'h40;    exp_out[2]  = 8'h20;
    exp_lfsr[0] = 15'h4000; exp_lfsr[1] = 15'h2000; exp_lfsr[2] = 15'h1000;

    rst = 1'b0; en = 1'b0; freq = 20'd0; mode = 1'b0;
    seed = 15'h0000; seed_load = 1'b0;
    repeat (3) step();
    check("reset_out", 32'(out), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_acc", 32'(dut.acc), 32'h0);
    check("reset_lfsr", 32'(dut.lfsr), 32'h1);

    // freq=25: ticks on edges 4, 8, 12 after release
    freq = 20'd25; en = 1'b1;
    rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("tick_valid_%0d", k), 32'(valid), 32'((k % 4) == 0));
      if ((k % 4) == 0) begin
        check($sformatf("tick_out_%0d", k), 32'(out), 32'(exp_out[k/4-1]));
        check($sformatf("tick_lfsr_%0d", k), 32'(dut.lfsr), 32'(exp_lfsr[k/4-1]));
      end
    end

    // en low for 20 cycles mid-interval: frozen output, no pulses
    repeat (2) step();
    en = 1'b0;
    nv = 0; nchg = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (valid) nv++;
      if (out !== 8'h20) nchg++;
    end
    check("en_low_valids", 32'(nv), 32'h0);
    check("en_low_out_changes", 32'(nchg), 32'h0);
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("en_rise_valid_%0d", k), 32'(valid), 32'(k == 4));
    end
    check("en_rise_out", 32'(out), 32'h10);
    check("en_rise_lfsr", 32'(dut.lfsr), 32'h0800);

    // freq=30 over 1000 cycles: 300 pulses spaced 3 or 4
    freq = 20'd30;
    nv = 0; gap = 0; bad_gap = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      gap++;
      if (valid) begin
        nv++;
        if (gap != 3 && gap != 4) bad_gap++;
        gap = 0;
      end
    end
    check("f30_pulses", 32'(nv), 32'd300);
    check("f30_bad_gaps", 32'(bad_gap), 32'h0);

    // freq=0: no pulses, output holds
    freq = 20'd0;
    held = out;
    nv = 0; nchg = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (valid) nv++;
      if (out !== held) nchg++;
    end
    check("f0_pulses", 32'(nv), 32'h0);
    check("f0_out_changes", 32'(nchg), 32'h0);

    // async reset right after a tick, between clock edges
    freq = 20'd25;
    n = 0;
    do begin
      step();
      n++;
    end while (!valid && n < 10);
    check("pre_reset_valid", 32'(valid), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", 32'(valid), 32'h0);
    check("async_rst_out", 32'(out), 32'h0);
    check("async_rst_acc", 32'(dut.acc), 32'h0);
    check("async_rst_lfsr", 32'(dut.lfsr), 32'h1);
    step();

    // freq >= BASE_SPEED: one step per cycle, full long and short periods
    freq = 20'd100; mode = 1'b0; en = 1'b1;
    rst = 1'b1;
    n = 0; nv = 0;
    do begin
      step();
      n++;
      if (valid) nv++;
    end while (dut.lfsr !== 15'h0001 && n < 40000);
    check("long_period", 32'(n), 32'd32767);
    check("long_valids", 32'(nv), 32'd32767);
    check("fast_acc_held", 32'(dut.acc), 32'h0);
    mode = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (dut.lfsr !== 15'h0001 && n < 200);
    check("short_period", 32'(n), 32'd93);

`ifdef NOISE_SEED_LOAD_EN
    // seed load of zero colliding with a tick
    rst = 1'b0; mode = 1'b0; freq = 20'd25;
    step();
    rst = 1'b1;
    repeat (3) step();
    seed = 15'h0000; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("load0_lfsr", 32'(dut.lfsr), 32'h1);
    check("load0_valid", 32'(valid), 32'h0);
    check("load0_acc", 32'(dut.acc), 32'h0);
    seed = 15'h7FFF; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("load_ones_out", 32'(out), 32'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
